memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words; it SHALL be a power of two.
REQ-002 The block SHALL have parameter LATENCY, default 1, giving the wait cycles between request accept and response (0..15).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req_valid, input, 1: the initiator presents a request.
REQ-006 Port req_ready, output, 1: the block can accept a request.
REQ-007 Port req_addr, input, 32: byte address.
REQ-008 Port req_wdata, input, 32: store data, right-aligned.
REQ-009 Port req_we, input, 1: 1 = store, 0 = load.
REQ-010 Port req_size, input, 2: 00 = byte, 01 = half, 10 = word; 11 is reserved.
REQ-011 Port req_unsigned, input, 1: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-012 Port rsp_valid, output, 1: a response is presented.
REQ-013 Port rsp_ready, input, 1: the initiator accepts the response.
REQ-014 Port rsp_rdata, output, 32: load result, extended to 32 bits; 0 for stores.
REQ-015 Port rsp_err, output, 1: the request was faulty (see Configuration).

Function
REQ-016 The block SHALL implement the states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-018 On accept, the block SHALL register addr, wdata, we, size and unsigned, and load the wait counter with LATENCY.
- Next state is WAIT if LATENCY>0, else RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at counter=1 the state SHALL become RESP.
REQ-020 The storage access SHALL occur on the edge that enters RESP.
- Accept-to-rsp_valid latency is LATENCY+1 cycles.
REQ-021 Word index SHALL be addr[31:2] modulo DEPTH_WORDS; lane selection SHALL use addr[1:0].
REQ-022 Stores SHALL write only the addressed byte lanes:
- byte: lane addr[1:0] takes wdata[7:0];
- half: lanes addr[1]*2 and addr[1]*2+1 take wdata[15:0];
- word: all lanes.
REQ-023 Loads SHALL extract the addressed byte or half, then sign- or zero-extend it according to the registered unsigned bit.
REQ-024 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; on that edge the state returns to IDLE.
REQ-025 A new request SHALL NOT be accepted in the same cycle a response completes; the next accept is possible no earlier than the following cycle.
REQ-026 req_size=11 SHALL be treated as word.

Reset
REQ-027 On reset assertion the block SHALL immediately:
- set the state to IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0;
- clear the counter.
REQ-028 Reset mid-operation SHALL drop the in-flight request; no store SHALL be committed unless its RESP-entry edge preceded the reset.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With MEMORY_RESPONDER_ERR_EN defined:
- rsp_err=1 for a misaligned half (addr[0]=1), a misaligned word (addr[1:0]≠0), or addr[31:2] ≥ DEPTH_WORDS;
- a faulty store SHALL NOT modify storage, and a faulty load SHALL return rsp_rdata=0;
- latency is unchanged.
REQ-031 Without MEMORY_RESPONDER_ERR_EN:
- rsp_err SHALL be tied to 0;
- misaligned half/word accesses SHALL force-align by ignoring addr[0] (half) or addr[1:0] (word);
- out-of-range addresses SHALL wrap modulo DEPTH_WORDS.

Verification
REQ-032 Word store then load, LATENCY=1: store 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_rdata=0xDEADBEEF; rsp_valid 2 cycles after each accept.
REQ-033 Byte lanes: word store 0x00000000 at 0x20, byte store 0x80 at 0x22, then:
- signed byte load at 0x22 -> 0xFFFFFF80;
- unsigned byte load at 0x22 -> 0x00000080;
- word load at 0x20 -> 0x00800000.
REQ-034 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-035 Reset mid-WAIT (LATENCY=4): assert reset 2 cycles after accepting a store of 0x12345678 to 0x40 -> rsp_valid=0 immediately; a later load at 0x40 returns the prior contents.
REQ-036 With MEMORY_RESPONDER_ERR_EN: word store 0xAAAA5555 to 0x42 -> rsp_err=1 and word 0x40 unchanged; without the macro, the same request writes word 0x40 and rsp_err=0.

Source files
------------

// File: rtl/memory_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with a fixed access latency.
// Optional fault reporting (misalignment, out-of-range) is built when MEMORY_RESPONDER_ERR_EN is defined.
module memory_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state_r;
   logic [3:0]    cnt_r;
   logic [31:0]   addr_r;
   logic [31:0]   wdata_r;
   logic          we_r;
   logic [1:0]    size_r;
   logic          uns_r;

   logic [31:0]   mem_r [DEPTH_WORDS];

   logic          accept_s;
   logic          enter_resp_s;
   logic [31:0]   acc_addr_s;
   logic [31:0]   acc_wdata_s;
   logic          acc_we_s;
   logic [1:0]    acc_size_s;
   logic          acc_uns_s;
   logic [1:0]    off_s;
   logic [3:0]    be_s;
   logic [31:0]   wlane_s;
   logic [AW-1:0] idx_s;
   logic [31:0]   lane_s;
   logic [31:0]   load_s;
   logic          err_s;

   // Sign- or zero-extend the low byte/half of an already lane-shifted word.
   function automatic logic [31:0] extend_load(input logic [31:0] lane, input logic [1:0] size,
                                               input logic uns);
      case (size)
         2'b00:   extend_load = uns ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         2'b01:   extend_load = uns ? {16'h0000, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: extend_load = lane;
      endcase
   endfunction

   assign accept_s     = req_valid && (state_r == IDLE);
   // With zero latency the access happens on the accept edge itself, so it must see the live request.
   assign enter_resp_s = (accept_s && (LATENCY == 0)) || ((state_r == WAIT) && (cnt_r <= 4'd1));

   // Select live request fields in IDLE, captured fields otherwise.
   always_comb begin
      if (state_r == IDLE) begin
         acc_addr_s  = req_addr;
         acc_wdata_s = req_wdata;
         acc_we_s    = req_we;
         acc_size_s  = req_size;
         acc_uns_s   = req_unsigned;
      end else begin
         acc_addr_s  = addr_r;
         acc_wdata_s = wdata_r;
         acc_we_s    = we_r;
         acc_size_s  = size_r;
         acc_uns_s   = uns_r;
      end
   end

   // Lane offset, byte enables and replicated store data; size 11 behaves as word.
   always_comb begin
      case (acc_size_s)
         2'b00: begin
            off_s   = acc_addr_s[1:0];
            be_s    = 4'b0001 << acc_addr_s[1:0];
            wlane_s = {4{acc_wdata_s[7:0]}};
         end
         2'b01: begin
            off_s   = {acc_addr_s[1], 1'b0};
            be_s    = 4'b0011 << {acc_addr_s[1], 1'b0};
            wlane_s = {2{acc_wdata_s[15:0]}};
         end
         default: begin
            off_s   = 2'b00;
            be_s    = 4'b1111;
            wlane_s = acc_wdata_s;
         end
      endcase
   end

   assign idx_s  = acc_addr_s[AW+1:2];
   assign lane_s = mem_r[idx_s] >> {off_s, 3'b000};
   assign load_s = extend_load(lane_s, acc_size_s, acc_uns_s);

`ifdef MEMORY_RESPONDER_ERR_EN
   // Flag misaligned half/word accesses and word indices beyond the array.
   always_comb begin
      case (acc_size_s)
         2'b00:   err_s = 1'b0;
         2'b01:   err_s = acc_addr_s[0];
         default: err_s = (acc_addr_s[1:0] != 2'b00);
      endcase
      if ({2'b00, acc_addr_s[31:2]} >= 32'(DEPTH_WORDS)) begin
         err_s = 1'b1;
      end else begin
         err_s = err_s;
      end
   end
`else
   logic unused_addr_s;
   assign err_s         = 1'b0;
   assign unused_addr_s = ^acc_addr_s[31:AW+2];
`endif

   // Storage commit on the RESP-entry edge; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (enter_resp_s && acc_we_s && !err_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               mem_r[idx_s][b*8 +: 8] <= wlane_s[b*8 +: 8];
            end
         end
      end
   end

   // Handshake FSM, request capture, wait counter and registered response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= 4'd0;
         addr_r    <= 32'h00000000;
         wdata_r   <= 32'h00000000;
         we_r      <= 1'b0;
         size_r    <= 2'b00;
         uns_r     <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h00000000;
         rsp_err   <= 1'b0;
      end else begin
         if (enter_resp_s) begin
            rsp_rdata <= (acc_we_s || err_s) ? 32'h00000000 : load_s;
            rsp_err   <= err_s;
         end
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  addr_r    <= req_addr;
                  wdata_r   <= req_wdata;
                  we_r      <= req_we;
                  size_r    <= req_size;
                  uns_r     <= req_unsigned;
                  cnt_r     <= 4'(LATENCY);
                  req_ready <= 1'b0;
                  if (LATENCY == 0) begin
                     state_r   <= RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state_r   <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_r <= cnt_r - 4'd1;
               if (cnt_r <= 4'd1) begin
                  state_r   <= RESP;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_r   <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: instance 0 uses LATENCY=1, instance 1 uses LATENCY=4.
// Expectations for faulty accesses follow MEMORY_RESPONDER_ERR_EN when it is defined.
module tb_memory_responder;

   localparam int LAT0 = 1;
   localparam int LAT1 = 4;

   logic             clk = 1'b0;
   logic [1:0]       rst = 2'b00;
   logic [1:0]       req_valid = 2'b00;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_addr = '0;
   logic [1:0][31:0] req_wdata = '0;
   logic [1:0]       req_we = 2'b00;
   logic [1:0][1:0]  req_size = '0;
   logic [1:0]       req_unsigned = 2'b00;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready = 2'b11;
   logic [1:0][31:0] rsp_rdata;
   logic [1:0]       rsp_err;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   memory_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT0)) u_dut0 (
      .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_we(req_we[0]),
      .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   memory_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT1)) u_dut1 (
      .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_we(req_we[1]),
      .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One full request/response; hold>0 stalls rsp_ready for that many cycles in RESP.
   task automatic xact(input int d, input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
      int lat;
      int exp_lat;
      exp_lat = ((d == 0) ? LAT0 : LAT1) + 1;
      @(negedge clk);
      check({tag, ":req_ready"}, 32'(req_ready[d]), 32'd1);
      req_we[d]       = we;
      req_size[d]     = size;
      req_unsigned[d] = uns;
      req_addr[d]     = addr;
      req_wdata[d]    = wdata;
      req_valid[d]    = 1'b1;
      rsp_ready[d]    = (hold == 0);
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         req_valid[d] = 1'b0;
         lat++;
      end while (!rsp_valid[d] && lat < 40);
      check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ":rdata"}, rsp_rdata[d], exp_rd);
      check({tag, ":err"}, 32'(rsp_err[d]), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ":hold_valid"}, 32'(rsp_valid[d]), 32'd1);
         check({tag, ":hold_rdata"}, rsp_rdata[d], exp_rd);
         check({tag, ":hold_req_ready"}, 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      check({tag, ":done_valid"}, 32'(rsp_valid[d]), 32'd0);
      check({tag, ":done_req_ready"}, 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      logic [31:0] e_rd;
      logic        e_err;
      #2 rst = 2'b11;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst:req_ready", 32'(req_ready[d]), 32'd1);
         check("rst:rsp_valid", 32'(rsp_valid[d]), 32'd0);
         check("rst:rsp_rdata", rsp_rdata[d], 32'h0);
         check("rst:rsp_err", 32'(rsp_err[d]), 32'd0);
      end
      @(negedge clk);
      rst = 2'b00;

      // word store/load, latency 2 after accept
      xact(0, "st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
      xact(0, "ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
      // half store into upper lanes, signed readback
      xact(0, "st_half", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0, 0);
      xact(0, "ld_half_s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
      xact(0, "ld_word_h", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEFBEEF, 1'b0, 0);
      // byte lanes
      xact(0, "st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000, 32'h0, 1'b0, 0);
      xact(0, "st_b22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h00000080, 32'h0, 1'b0, 0);
      xact(0, "ld_b_s", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'hFFFFFF80, 1'b0, 0);
      xact(0, "ld_b_u", 1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 32'h00000080, 1'b0, 0);
      xact(0, "ld_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00800000, 1'b0, 0);
      xact(0, "ld_sz11", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h00800000, 1'b0, 0);
      // backpressure for 5 cycles
      xact(0, "bp", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEFBEEF, 1'b0, 5);

      // misaligned word store and misaligned half load
      xact(0, "st_w40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, 32'h0, 1'b0, 0);
`ifdef MEMORY_RESPONDER_ERR_EN
      xact(0, "st_mis", 1'b1, 2'b10, 1'b0, 32'h42, 32'hAAAA5555, 32'h0, 1'b1, 0);
      e_rd = 32'h11111111;
`else
      xact(0, "st_mis", 1'b1, 2'b10, 1'b0, 32'h42, 32'hAAAA5555, 32'h0, 1'b0, 0);
      e_rd = 32'hAAAA5555;
`endif
      xact(0, "ld_w40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, e_rd, 1'b0, 0);
`ifdef MEMORY_RESPONDER_ERR_EN
      e_rd = 32'h0;  e_err = 1'b1;
`else
      e_rd = 32'h00000080;  e_err = 1'b0;
`endif
      xact(0, "ld_h_mis", 1'b0, 2'b01, 1'b0, 32'h23, 32'h0, e_rd, e_err, 0);
      // out-of-range: wraps to word 0 or faults
      xact(0, "st_w0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, 32'h0, 1'b0, 0);
`ifdef MEMORY_RESPONDER_ERR_EN
      e_rd = 32'h0;  e_err = 1'b1;
`else
      e_rd = 32'h0BADF00D;  e_err = 1'b0;
`endif
      xact(0, "ld_oor", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, e_rd, e_err, 0);

      // reset two cycles into WAIT drops the store (LATENCY=4 instance)
      xact(1, "l4_st", 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 0);
      @(negedge clk);
      req_we[1]    = 1'b1;
      req_size[1]  = 2'b10;
      req_addr[1]  = 32'h40;
      req_wdata[1] = 32'h12345678;
      req_valid[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst[1] = 1'b1;
      #1;
      check("midrst:rsp_valid", 32'(rsp_valid[1]), 32'd0);
      check("midrst:req_ready", 32'(req_ready[1]), 32'd1);
      @(negedge clk);
      rst[1] = 1'b0;
      xact(1, "l4_ld", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
